// File: rtl/io_uart_pkg.sv
`default_nettype none
// ============================================================================
// Package     : io_uart_pkg
// Description : Shared types and register map for the io-bus UART transmitter.
// Revision    : 1.0 - initial release
// ============================================================================
package io_uart_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } tx_state_t;

    // Register offsets relative to BASE_ADDR
    localparam logic [15:0] OFS_TX_DATA = 16'd0;
    localparam logic [15:0] OFS_STATUS  = 16'd1;

    // STATUS bit positions; count occupies [15:8]
    localparam int ST_FULL  = 0;
    localparam int ST_EMPTY = 1;
    localparam int ST_BUSY  = 2;
    localparam int ST_OVF   = 3;

    // Writing a 1 here in a STATUS store clears the overflow flag
    localparam int CLR_OVF_BIT = 3;

endpackage
`default_nettype wire

// File: rtl/sync_fifo.sv
`default_nettype none
// ============================================================================
// Module      : sync_fifo
// Description : Single-clock FIFO with show-ahead head and occupancy count.
// Revision    : 1.0 - initial release
// ============================================================================
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   push,
    input  logic [WIDTH-1:0]       push_data,
    input  logic                   pop,
    output logic [WIDTH-1:0]       head,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count
);

    localparam int            c_AW     = $clog2(DEPTH);
    localparam logic [c_AW:0] c_FULL   = DEPTH[c_AW:0];
    localparam logic [c_AW:0] c_ONE    = {{c_AW{1'b0}}, 1'b1};
    localparam logic [c_AW-1:0] c_STEP = {{(c_AW-1){1'b0}}, 1'b1};

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [c_AW-1:0]  r_wr_ptr;
    logic [c_AW-1:0]  r_rd_ptr;
    logic [c_AW:0]    r_count;
    logic             w_do_push;
    logic             w_do_pop;

    assign empty = (r_count == '0);
    assign full  = (r_count == c_FULL);
    assign count = r_count;
    assign head  = r_mem[r_rd_ptr];

    // A pop in the same cycle frees the slot, so a full FIFO still accepts
    assign w_do_pop  = pop & ~empty;
    assign w_do_push = push & (~full | w_do_pop);

    always_ff @(posedge clock) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + c_STEP;
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + c_STEP;
            end
            if (w_do_push && !w_do_pop) begin
                r_count <= r_count + c_ONE;
            end else if (w_do_pop && !w_do_push) begin
                r_count <= r_count - c_ONE;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= push_data;
        end
    end

endmodule
`default_nettype wire

// File: rtl/io_uart_tx.sv
`default_nettype none
// ============================================================================
// Module      : io_uart_tx
// Description : Memory-mapped UART transmitter: TX_DATA push, STATUS poll,
//               FIFO-fed 8N1 serialiser. Define IO_UART_TX_PARITY_EN to
//               insert an even parity bit (11 bit-time frames).
// Revision    : 1.0 - initial release
// ============================================================================
module io_uart_tx
    import io_uart_pkg::*;
#(
    parameter int          CLK_HZ     = 50_000_000,
    parameter int          BAUD       = 115200,
    parameter int          FIFO_DEPTH = 16,
    parameter logic [15:0] BASE_ADDR  = 16'hFF10
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [15:0] waddr,
    input  logic [15:0] wdata,
    input  logic        wenable,
    input  logic [15:0] raddr,
    output logic [15:0] rdata,
    output logic        uart_txd,
    output logic        tx_irq
);

    localparam int                  c_BIT_TICKS   = CLK_HZ / BAUD;
    localparam int                  c_TICK_W      = $clog2(c_BIT_TICKS);
    localparam int                  c_CNT_W       = $clog2(FIFO_DEPTH) + 1;
    localparam logic [c_TICK_W-1:0] c_TICK_LAST   = c_TICK_W'(c_BIT_TICKS - 1);
    localparam logic [c_TICK_W-1:0] c_TICK_ONE    = c_TICK_W'(1);
    localparam logic [15:0]         c_ADDR_DATA   = BASE_ADDR + OFS_TX_DATA;
    localparam logic [15:0]         c_ADDR_STATUS = BASE_ADDR + OFS_STATUS;

    tx_state_t           r_state;
    tx_state_t           w_state_next;
    logic [c_TICK_W-1:0] r_baud_cnt;
    logic [c_TICK_W-1:0] w_baud_next;
    logic [2:0]          r_bit_cnt;
    logic [2:0]          w_bit_next;
    logic [7:0]          r_shift;
    logic [7:0]          w_shift_next;
    logic                r_txd;
    logic                w_txd_next;
    logic                r_ovf;
    logic                r_irq;
    logic [15:0]         r_rdata;
    logic [15:0]         w_status;
    logic                w_push_req;
    logic                w_clr_ovf;
    logic                w_pop;
    logic                w_load;
    logic                w_busy;
    logic                w_bit_done;
    logic [7:0]          w_head;
    logic                w_full;
    logic                w_empty;
    logic [c_CNT_W-1:0]  w_count;
    logic [7:0]          w_unused_wdata;
`ifdef IO_UART_TX_PARITY_EN
    logic                r_parity;
    logic                w_parity_next;
`endif

    assign w_push_req     = wenable & (waddr == c_ADDR_DATA);
    assign w_clr_ovf      = wenable & (waddr == c_ADDR_STATUS) & wdata[CLR_OVF_BIT];
    assign w_busy         = (r_state != IDLE);
    assign w_bit_done     = (r_baud_cnt == '0);
    assign w_unused_wdata = wdata[15:8];

    // Next byte is taken from IDLE, or straight out of STOP so frames abut
    assign w_load = ~w_empty & ((r_state == IDLE) | ((r_state == STOP) & w_bit_done));

    sync_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clock     (clock),
        .reset     (reset),
        .push      (w_push_req),
        .push_data (wdata[7:0]),
        .pop       (w_pop),
        .head      (w_head),
        .full      (w_full),
        .empty     (w_empty),
        .count     (w_count)
    );

    always_comb begin
        w_state_next = r_state;
        w_bit_next   = r_bit_cnt;
        w_shift_next = r_shift;
        w_baud_next  = r_baud_cnt;
        w_pop        = 1'b0;
`ifdef IO_UART_TX_PARITY_EN
        w_parity_next = r_parity;
`endif
        if (r_state != IDLE) begin
            w_baud_next = w_bit_done ? c_TICK_LAST : (r_baud_cnt - c_TICK_ONE);
        end

        case (r_state)
            IDLE: begin
                w_state_next = IDLE;
            end
            START: begin
                if (w_bit_done) begin
                    w_state_next = DATA;
                    w_bit_next   = 3'd0;
                end
            end
            DATA: begin
                if (w_bit_done) begin
                    w_shift_next = {1'b0, r_shift[7:1]};
                    w_bit_next   = r_bit_cnt + 3'd1;
                    if (r_bit_cnt == 3'd7) begin
`ifdef IO_UART_TX_PARITY_EN
                        w_state_next = PARITY;
`else
                        w_state_next = STOP;
`endif
                    end
                end
            end
`ifdef IO_UART_TX_PARITY_EN
            PARITY: begin
                if (w_bit_done) begin
                    w_state_next = STOP;
                end
            end
`endif
            STOP: begin
                if (w_bit_done) begin
                    w_state_next = IDLE;
                end
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase

        if (w_load) begin
            w_pop        = 1'b1;
            w_state_next = START;
            w_shift_next = w_head;
            w_baud_next  = c_TICK_LAST;
`ifdef IO_UART_TX_PARITY_EN
            w_parity_next = ^w_head;
`endif
        end
    end

    // Line level is registered from the next state so uart_txd is glitch-free
    always_comb begin
        w_txd_next = 1'b1;
        case (w_state_next)
            START:   w_txd_next = 1'b0;
            DATA:    w_txd_next = w_shift_next[0];
`ifdef IO_UART_TX_PARITY_EN
            PARITY:  w_txd_next = w_parity_next;
`endif
            default: w_txd_next = 1'b1;
        endcase
    end

    always_comb begin
        w_status           = 16'h0000;
        w_status[15:8]     = 8'(w_count);
        w_status[ST_FULL]  = w_full;
        w_status[ST_EMPTY] = w_empty;
        w_status[ST_BUSY]  = w_busy;
        w_status[ST_OVF]   = r_ovf;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state    <= IDLE;
            r_baud_cnt <= '0;
            r_bit_cnt  <= '0;
            r_shift    <= '0;
            r_txd      <= 1'b1;
            r_ovf      <= 1'b0;
            r_irq      <= 1'b1;
            r_rdata    <= 16'h0000;
`ifdef IO_UART_TX_PARITY_EN
            r_parity   <= 1'b0;
`endif
        end else begin
            r_state    <= w_state_next;
            r_baud_cnt <= w_baud_next;
            r_bit_cnt  <= w_bit_next;
            r_shift    <= w_shift_next;
            r_txd      <= w_txd_next;
            r_irq      <= w_empty & ~w_busy;
`ifdef IO_UART_TX_PARITY_EN
            r_parity   <= w_parity_next;
`endif
            if (w_push_req && w_full && !w_pop) begin
                r_ovf <= 1'b1;
            end else if (w_clr_ovf) begin
                r_ovf <= 1'b0;
            end
            // TX_DATA and unmapped addresses read as zero for the OR-combined bus
            r_rdata <= (raddr == c_ADDR_STATUS) ? w_status : 16'h0000;
        end
    end

    assign uart_txd = r_txd;
    assign tx_irq   = r_irq;
    assign rdata    = r_rdata;

endmodule
`default_nettype wire

// File: tb/tb_io_uart_tx.sv
`default_nettype none
// ============================================================================
// Module      : tb_io_uart_tx
// Description : Scoreboard bench for io_uart_tx: a line monitor decodes frames
//               and compares them with bytes queued by the stimulus.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_io_uart_tx;

    localparam int c_BIT = 10;
`ifdef IO_UART_TX_PARITY_EN
    localparam int c_FRAME_BITS = 11;
`else
    localparam int c_FRAME_BITS = 10;
`endif
    localparam int          c_FRAME_CLKS = c_FRAME_BITS * c_BIT;
    localparam logic [15:0] c_TXD        = 16'hFF10;
    localparam logic [15:0] c_STAT       = 16'hFF11;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] waddr;
    logic [15:0] wdata;
    logic        wenable;
    logic [15:0] raddr;
    logic [15:0] rdata;
    logic        uart_txd;
    logic        tx_irq;

    int n_assert = 0;
    int n_fail   = 0;
    int cyc      = 0;
    logic txd_d  = 1'b1;

    typedef struct {
        logic [7:0] data;
        logic       par;
        int         start;   // >=0 exact start cycle, -2 abuts previous frame, -1 any
    } exp_t;

    exp_t exp_q[$];
    bit   mon_abort = 1'b0;
    bit   mon_busy  = 1'b0;
    int   last_s    = -100000;

    io_uart_tx #(
        .CLK_HZ     (1_000_000),
        .BAUD       (100_000),
        .FIFO_DEPTH (4),
        .BASE_ADDR  (16'hFF10)
    ) dut (
        .clock    (clk),
        .reset    (reset),
        .waddr    (waddr),
        .wdata    (wdata),
        .wenable  (wenable),
        .raddr    (raddr),
        .rdata    (rdata),
        .uart_txd (uart_txd),
        .tx_irq   (tx_irq)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    always @(negedge clk) txd_d <= uart_txd;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_assert++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic expect_frame(input logic [7:0] d, input logic p, input int s);
        exp_t e;
        e.data  = d;
        e.par   = p;
        e.start = s;
        exp_q.push_back(e);
    endtask

    task automatic io_write(input logic [15:0] a, input logic [15:0] d);
        waddr   = a;
        wdata   = d;
        wenable = 1'b1;
        @(posedge clk); #1;
        wenable = 1'b0;
        waddr   = 16'h0000;
    endtask

    task automatic io_read(input string name, input logic [15:0] a, input logic [15:0] exp);
        raddr = a;
        @(posedge clk); #1;
        check(name, {16'h0000, rdata}, {16'h0000, exp});
        raddr = 16'h0000;
    endtask

    task automatic drain(input int budget);
        int n;
        n = 0;
        while ((exp_q.size() != 0 || mon_busy) && n < budget) begin
            @(posedge clk); #1;
            n++;
        end
        check("frames_drained", {31'd0, n < budget}, 32'd1);
        exp_q.delete();
        repeat (20) @(posedge clk);
        #1;
    endtask

    // Line monitor: decode each frame at mid-bit and score it
    initial begin : monitor
        exp_t        e;
        int          s;
        logic [10:0] bits;
        bit          aborted;
        forever begin
            @(negedge clk);
            if (reset === 1'b0 && txd_d === 1'b1 && uart_txd === 1'b0) begin
                s = cyc;
                if (exp_q.size() == 0) begin
                    n_assert++;
                    n_fail++;
                    $display("FAIL unexpected_frame: start bit at cycle %0d, none expected", s);
                end else begin
                    e        = exp_q.pop_front();
                    mon_busy = 1'b1;
                    aborted  = 1'b0;
                    bits     = '1;
                    for (int k = 0; k < c_FRAME_BITS; k++) begin
                        while (cyc != s + c_BIT * k + c_BIT / 2 - 1 && !mon_abort) @(negedge clk);
                        if (mon_abort) begin
                            aborted = 1'b1;
                            break;
                        end
                        bits[k] = uart_txd;
                    end
                    if (!aborted) begin
                        if (e.start >= 0) begin
                            check("frame_start_cycle", s, e.start);
                        end else if (e.start == -2) begin
                            check("frame_contiguous", s, last_s + c_FRAME_CLKS);
                        end
                        check("start_bit", {31'd0, bits[0]}, 32'd0);
                        check("data_byte", {24'd0, bits[8:1]}, {24'd0, e.data});
`ifdef IO_UART_TX_PARITY_EN
                        check("parity_bit", {31'd0, bits[9]}, {31'd0, e.par});
`endif
                        check("stop_bit", {31'd0, bits[c_FRAME_BITS-1]}, 32'd1);
                        last_s = s;
                    end
                    mon_busy = 1'b0;
                end
            end
        end
    end

    initial begin : watchdog
        repeat (40000) @(posedge clk);
        $display("FAIL watchdog: test did not complete (got cycle %0d, expected < 40000)", cyc);
        n_fail++;
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $fatal(1, "watchdog expired");
    end

    initial begin : stim
        int w;
        reset   = 1'b1;
        wenable = 1'b0;
        waddr   = 16'h0000;
        wdata   = 16'h0000;
        raddr   = 16'h0000;
        repeat (3) @(posedge clk);
        #1;
        check("reset_txd", {31'd0, uart_txd}, 32'd1);
        check("reset_irq", {31'd0, tx_irq}, 32'd1);
        check("reset_rdata", {16'h0000, rdata}, 32'h0000_0000);
        reset = 1'b0;

        // Idle: line high, interrupt asserted, STATUS shows only empty
        raddr = c_STAT;
        for (int i = 0; i < 1000; i++) begin
            @(posedge clk); #1;
            if (i % 100 == 99) begin
                check("idle_txd", {31'd0, uart_txd}, 32'd1);
                check("idle_irq", {31'd0, tx_irq}, 32'd1);
                check("idle_status", {16'h0000, rdata}, 32'h0000_0002);
            end
        end
        raddr = 16'h0000;

        // Single byte, upper data byte ignored; start bit two clocks after the store
        w = cyc;
        expect_frame(8'h55, 1'b0, w + 2);
        io_write(c_TXD, 16'hAB55);
        repeat (20) @(posedge clk);
        #1;
        check("busy_irq_low", {31'd0, tx_irq}, 32'd0);
        io_read("status_busy", c_STAT, 16'h0006);
        io_read("read_txdata_zero", c_TXD, 16'h0000);
        io_read("read_unmapped_zero", 16'h1234, 16'h0000);
        drain(3 * c_FRAME_CLKS);
        check("irq_after_frame", {31'd0, tx_irq}, 32'd1);

        // Six back-to-back stores: 01 moves to the shifter, 02..05 fill the FIFO, 06 overflows
        w = cyc;
        expect_frame(8'h01, 1'b1, w + 2);
        expect_frame(8'h02, 1'b1, -2);
        expect_frame(8'h03, 1'b0, -2);
        expect_frame(8'h04, 1'b1, -2);
        expect_frame(8'h05, 1'b0, -2);
        for (int i = 1; i <= 6; i++) io_write(c_TXD, 16'(i));
        io_read("status_full_ovf", c_STAT, 16'h040D);
        io_write(c_STAT, 16'hFFF7);
        io_read("status_ovf_kept", c_STAT, 16'h040D);
        io_write(c_STAT, 16'h0008);
        io_read("status_ovf_cleared", c_STAT, 16'h0405);
        drain(6 * c_FRAME_CLKS);
        io_read("status_drained", c_STAT, 16'h0002);

        // Store lands on the STOP->START pop while the FIFO is full
        w = cyc;
        expect_frame(8'hA1, 1'b1, w + 2);
        expect_frame(8'hA2, 1'b1, -2);
        expect_frame(8'hA3, 1'b0, -2);
        expect_frame(8'hA4, 1'b1, -2);
        expect_frame(8'hA5, 1'b0, -2);
        expect_frame(8'hA6, 1'b0, -2);
        for (int i = 0; i < 5; i++) io_write(c_TXD, 16'h00A1 + 16'(i));
        io_read("status_full_no_ovf", c_STAT, 16'h0405);
        while (cyc < w + 1 + c_FRAME_CLKS) begin
            @(posedge clk); #1;
        end
        io_write(c_TXD, 16'h00A6);
        io_read("status_push_at_pop", c_STAT, 16'h0405);
        drain(8 * c_FRAME_CLKS);

        // Reset during data bit 3 of F0 (a zero bit); queued 33 must be discarded
        w = cyc;
        expect_frame(8'hF0, 1'b0, w + 2);
        io_write(c_TXD, 16'h00F0);
        io_write(c_TXD, 16'h0033);
        while (cyc < w + 2 + 4 * c_BIT + 3) begin
            @(posedge clk); #1;
        end
        check("pre_reset_txd_low", {31'd0, uart_txd}, 32'd0);
        mon_abort = 1'b1;
        reset     = 1'b1;
        @(posedge clk); #1;
        check("reset_midframe_txd", {31'd0, uart_txd}, 32'd1);
        check("reset_midframe_irq", {31'd0, tx_irq}, 32'd1);
        reset = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        mon_abort = 1'b0;
        check("abort_queue_empty", exp_q.size(), 32'd0);
        io_read("status_after_reset", c_STAT, 16'h0002);
        for (int i = 0; i < 4; i++) begin
            repeat (50) @(posedge clk);
            #1;
            check("no_resume_txd", {31'd0, uart_txd}, 32'd1);
        end

        // Parity vectors: 07 has odd weight, 03 even
        w = cyc;
        expect_frame(8'h07, 1'b1, w + 2);
        expect_frame(8'h03, 1'b0, -2);
        io_write(c_TXD, 16'h0007);
        io_write(c_TXD, 16'h0003);
        drain(4 * c_FRAME_CLKS);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
